// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and receiver state encoding, shared by the VGA
// timing generator and the sync receiver.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned H_BP        = 48;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_BP        = 33;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned LOCK_FRAMES = 2;

  localparam int unsigned HcWidth  = 11;
  localparam int unsigned VcWidth  = 10;
  localparam int unsigned ErrWidth = 8;

  typedef enum logic [1:0] {
    StSearch,
    StCheck,
    StLocked
  } sync_state_e;

  function automatic logic [ErrWidth-1:0] sat_inc_err(input logic [ErrWidth-1:0] v);
    return (v == {ErrWidth{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an active-low sync input, with a falling-edge
// strobe that is only evaluated on pixel-enable cycles.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic sig_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    if (pix_en) begin
      prev_d = sync_q;
    end
  end

  // Idle level of the sync lines is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      prev_q <= prev_d;
    end
  end

  assign fall_o = pix_en & prev_q & ~sync_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates and frame markers from Hsync/Vsync, and checks
// line/frame lengths against the expected timing to report lock and errors.
module vga_sync_receiver #(
  parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
  parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
  parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int unsigned LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt
);

  import vga_timing_pkg::*;

  localparam logic [HcWidth-1:0] HcMax      = {HcWidth{1'b1}};
  localparam logic [HcWidth-1:0] HcLostAt   = HcMax - 1'b1;
  localparam logic [HcWidth-1:0] HcLineEnd  = HcWidth'(H_TOTAL - 1);
  localparam logic [HcWidth-1:0] HcVisFirst = HcWidth'(H_SYNC + H_BP);
  localparam logic [HcWidth-1:0] HcVisLast  = HcWidth'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VcWidth-1:0] VcFrameEnd = VcWidth'(V_TOTAL - 1);
  localparam logic [VcWidth-1:0] VcVisFirst = VcWidth'(V_SYNC + V_BP);
  localparam logic [VcWidth-1:0] VcVisLast  = VcWidth'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [3:0]         GoodTarget = 4'(LOCK_FRAMES);

  logic h_fall;
  logic v_fall;

  sync_edge_detect u_hsync_edge (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .sig_i  (hsync),
    .fall_o (h_fall)
  );

  sync_edge_detect u_vsync_edge (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .sig_i  (vsync),
    .fall_o (v_fall)
  );

  logic [HcWidth-1:0]  hc_q, hc_d;
  logic [VcWidth-1:0]  vc_q, vc_d;
  sync_state_e         state_q, state_d;
  logic [3:0]          good_q, good_d;
  logic                skip_q, skip_d;
  logic [ErrWidth-1:0] err_cnt_q, err_cnt_d;
  logic                err_q, err_d;
  logic                fs_q, fs_d;
  logic                locked_q, locked_d;
  logic                active_q, active_d;
  logic [9:0]          x_q, x_d;
  logic [8:0]          y_q, y_d;

  logic line_bad;
  logic frame_bad;
  logic sync_lost;
  logic mismatch;

  // Pixel and line counters; the vsync edge wins over a coincident hsync edge.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (h_fall) begin
        hc_d = '0;
      end else if (hc_q != HcMax) begin
        hc_d = hc_q + 1'b1;
      end
      if (v_fall) begin
        vc_d = '0;
      end else if (h_fall) begin
        vc_d = vc_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    skip_d    = skip_q;
    line_bad  = 1'b0;
    frame_bad = 1'b0;
    // Sync loss is flagged once, on the sample that drives hc into saturation.
    sync_lost = pix_en && !h_fall && (hc_q == HcLostAt);

    if (state_q != StSearch) begin
      if (h_fall) begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else begin
          line_bad = (hc_q != HcLineEnd);
        end
      end
      frame_bad = v_fall && (vc_q != VcFrameEnd);
    end

    mismatch = line_bad | frame_bad | sync_lost;

    if (mismatch) begin
      good_d = '0;
      if (v_fall) begin
        state_d = StCheck;
        skip_d  = 1'b1;
      end else begin
        state_d = StSearch;
      end
    end else if (v_fall) begin
      case (state_q)
        StSearch: begin
          state_d = StCheck;
          good_d  = '0;
          skip_d  = 1'b1;
        end
        StCheck: begin
          good_d = good_q + 1'b1;
          if (good_d == GoodTarget) begin
            state_d = StLocked;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Outputs reflect the post-sample counter and state values.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mismatch) begin
      err_cnt_d = sat_inc_err(err_cnt_q);
    end
    err_d    = mismatch;
    fs_d     = v_fall && (state_q == StLocked) && (state_d == StLocked);
    locked_d = (state_d == StLocked);
    active_d = locked_d &&
               (hc_d >= HcVisFirst) && (hc_d <= HcVisLast) &&
               (vc_d >= VcVisFirst) && (vc_d <= VcVisLast);
    x_d = '0;
    y_d = '0;
    if (active_d) begin
      x_d = 10'(hc_d - HcVisFirst);
      y_d = 9'(vc_d - VcVisFirst);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q      <= '0;
      vc_q      <= '0;
      state_q   <= StSearch;
      good_q    <= '0;
      skip_q    <= 1'b0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
      active_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      state_q   <= state_d;
      good_q    <= good_d;
      skip_q    <= skip_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      fs_q      <= fs_d;
      locked_q  <= locked_d;
      active_q  <= active_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down timing so whole frames fit the
// cycle budget; a rule-level receiver model predicts every output per strobe.
module tb_vga_sync_receiver;

  localparam int HA = 8, HS = 2, HB = 2, HT = 14;
  localparam int VA = 4, VS = 1, VB = 2, VT = 9;
  localparam int LF = 2;
  localparam int HOFF = HS + HB, VOFF = VS + VB;
  localparam int ModeHunt = 0, ModeVerify = 1, ModeLocked = 2;

  logic       clk = 1'b0;
  logic       rst, pix_en, hsync, vsync;
  logic [9:0] x;
  logic [8:0] y;
  logic       active, frame_start, locked, err;
  logic [7:0] err_cnt;

  vga_sync_receiver #(
    .H_ACTIVE    (HA),
    .H_SYNC      (HS),
    .H_BP        (HB),
    .H_TOTAL     (HT),
    .V_ACTIVE    (VA),
    .V_SYNC      (VS),
    .V_BP        (VB),
    .V_TOTAL     (VT),
    .LOCK_FRAMES (LF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .x           (x),
    .y           (y),
    .active      (active),
    .frame_start (frame_start),
    .locked      (locked),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fs_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic m_hprev, m_vprev, pend_h, pend_v;
  int   m_hc, m_vc, m_mode, m_good, m_errs;
  logic m_skip;
  logic e_err, e_fs, e_lock, e_act;
  int   e_x, e_y;

  task automatic model_reset();
    m_hprev = 1'b1; m_vprev = 1'b1; pend_h = 1'b1; pend_v = 1'b1;
    m_hc = 0; m_vc = 0; m_mode = ModeHunt; m_good = 0; m_errs = 0; m_skip = 1'b0;
    e_err = 1'b0; e_fs = 1'b0; e_lock = 1'b0; e_act = 1'b0; e_x = 0; e_y = 0;
  endtask

  task automatic model_step(input logic h, input logic v);
    logic hf, vf, was_lock, fault;
    hf = m_hprev && !h;
    vf = m_vprev && !v;
    was_lock = (m_mode == ModeLocked);
    fault = !hf && (m_hc == 2046);
    if (m_mode != ModeHunt) begin
      if (hf && m_skip) m_skip = 1'b0;
      else if (hf && m_hc != HT - 1) fault = 1'b1;
      if (vf && m_vc != VT - 1) fault = 1'b1;
    end
    if (fault) begin
      m_errs = (m_errs < 255) ? m_errs + 1 : 255;
      m_good = 0;
      if (vf) begin m_mode = ModeVerify; m_skip = 1'b1; end
      else m_mode = ModeHunt;
    end else if (vf && m_mode == ModeHunt) begin
      m_mode = ModeVerify; m_good = 0; m_skip = 1'b1;
    end else if (vf && m_mode == ModeVerify) begin
      m_good++;
      if (m_good == LF) m_mode = ModeLocked;
    end
    m_hc = hf ? 0 : ((m_hc < 2047) ? m_hc + 1 : 2047);
    m_vc = vf ? 0 : (hf ? (m_vc + 1) % 1024 : m_vc);
    e_err  = fault;
    e_lock = (m_mode == ModeLocked);
    e_fs   = vf && was_lock && e_lock;
    e_act  = e_lock && m_hc >= HOFF && m_hc < HOFF + HA && m_vc >= VOFF && m_vc < VOFF + VA;
    e_x    = e_act ? m_hc - HOFF : 0;
    e_y    = e_act ? m_vc - VOFF : 0;
    m_hprev = h;
    m_vprev = v;
  endtask

  function automatic logic [31:0] dut_bus();
    return {1'b0, x, y, active, frame_start, locked, err, err_cnt};
  endfunction

  function automatic logic [31:0] exp_bus();
    return {1'b0, 10'(e_x), 9'(e_y), e_act, e_fs, e_lock, e_err, 8'(m_errs)};
  endfunction

  // One pixel strobe; the DUT sees the previous strobe's levels through its synchroniser.
  task automatic pixel(input logic h, input logic v);
    int gap;
    @(negedge clk);
    hsync = h; vsync = v; pix_en = 1'b1;
    @(posedge clk);
    #1;
    model_step(pend_h, pend_v);
    pend_h = h; pend_v = v;
    check("pix", dut_bus(), exp_bus());
    if (frame_start) fs_seen++;
    gap = $urandom_range(1, 3);
    @(negedge clk);
    pix_en = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      if (i == 0 && (e_err || e_fs)) check("pulse_width", {30'd0, err, frame_start}, 32'd0);
      if (i < gap - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int nlines, input int short_ln, input int stall_px,
                            input bit probe);
    int len;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int px = 0; px < len; px++) begin
        if (stall_px >= 0 && ln == VOFF + 1 && px == stall_px) begin
          repeat (8) begin
            @(negedge clk);
            hsync = 1'($urandom); vsync = 1'($urandom);
          end
          @(negedge clk);
          hsync = pend_h; vsync = pend_v;
          repeat (2) @(posedge clk);
          #1 check("stall_hold", dut_bus(), exp_bus());
        end
        pixel(px >= HS, ln >= VS);
        if (probe) begin
          if (ln == VOFF && px == HOFF + 1)
            check("first_px", {12'd0, x, y, active}, {12'd0, 10'd0, 9'd0, 1'b1});
          if (ln == VOFF + VA - 1 && px == HOFF + HA)
            check("last_px", {12'd0, x, y, active}, {12'd0, 10'(HA - 1), 9'(VA - 1), 1'b1});
          if (ln == VOFF + VA - 1 && px == HOFF + HA + 1)
            check("past_px", {21'd0, x, active}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nl, sl, e0;
    rst = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("reset", dut_bus(), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Acquire lock from reset
    send_frame(VT, -1, -1, 0); check("acq_f1", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 0); check("acq_f2", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 0); check("acq_f3", {31'd0, locked}, 32'd1);
    check("acq_errcnt", {24'd0, err_cnt}, 32'd0);
    fs_seen = 0;
    send_frame(VT, -1, -1, 1);
    check("fs_once", fs_seen, 32'd1);

    // One short line while locked
    send_frame(VT, $urandom_range(0, VT - 2), -1, 0);
    check("sl_unlock", {31'd0, locked}, 32'd0);
    check("sl_errcnt", {24'd0, err_cnt}, 32'd1);
    send_frame(VT, -1, -1, 0); check("sl_f1", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 0); check("sl_f2", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 0); check("sl_f3", {31'd0, locked}, 32'd1);

    // One frame a line short: error lands on the vsync fall, recovery via CHECK
    send_frame(VT - 1, -1, -1, 0); check("sf_still", {31'd0, locked}, 32'd1);
    send_frame(VT, -1, -1, 0);
    check("sf_unlock", {31'd0, locked}, 32'd0);
    check("sf_errcnt", {24'd0, err_cnt}, 32'd2);
    send_frame(VT, -1, -1, 0); check("sf_f1", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 0); check("sf_f2", {31'd0, locked}, 32'd1);

    // pix_en held low mid-frame while sync lines wiggle
    send_frame(VT, -1, HOFF + 3, 1);

    // Randomised frame lengths and short lines
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(VT - 1, VT + 1);
      sl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nl - 1) : -1;
      send_frame(nl, sl, -1, 0);
    end
    repeat (3) send_frame(VT, -1, -1, 0);
    check("relock", {31'd0, locked}, 32'd1);

    // Both syncs stuck low
    e0 = m_errs;
    repeat (3000) pixel(1'b0, 1'b0);
    check("stuck_err", {24'd0, err_cnt}, 32'(e0 + 1));
    check("stuck_unlock", {31'd0, locked}, 32'd0);
    repeat (3) send_frame(VT, -1, -1, 0);
    check("stuck_r3", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 0);
    check("stuck_r4", {31'd0, locked}, 32'd1);

    // Asynchronous reset mid-line, then reacquire
    send_frame(2, -1, -1, 0);
    for (int px = 0; px < 5; px++) pixel(1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 check("async_rst", dut_bus(), 32'd0);
    model_reset();
    hsync = 1'b1; vsync = 1'b1;
    repeat (4) begin
      @(negedge clk) pix_en = 1'b1;
      @(negedge clk) pix_en = 1'b0;
    end
    check("rst_hold", dut_bus(), 32'd0);
    @(negedge clk) rst = 1'b1;
    send_frame(VT, -1, -1, 0); check("rr_f1", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 0); check("rr_f2", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, -1, 1); check("rr_f3", {31'd0, locked}, 32'd1);
    check("rr_errcnt", {24'd0, err_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink end of the VGA timing interface: takes Hsync/Vsync as produced by the game's VGA timing generator and recovers pixel coordinates, an active-video flag and frame markers.
- Checks that line and frame lengths match 640x480@60 timing and reports lock and error status.
- Used as an on-board timing monitor and as the checker in system benches; it sits beside the VGA output pins and runs on the board clock, gated by the pixel-rate enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_SYNC, 96, hsync pulse width in pixels
H_BP, 48, back porch in pixels
H_TOTAL, 800, pixels per line
V_ACTIVE, 480, visible lines
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, back porch in lines
V_TOTAL, 525, lines per frame
LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
clk  in  1  board clock; all logic is on its rising edge
rst  in  1  asynchronous, active-low reset
pix_en  in  1  one-cycle strobe at pixel rate (25 MHz); sampling and counting occur only when high
hsync  in  1  active-low horizontal sync
vsync  in  1  active-low vertical sync
x  out  10  recovered column, 0..H_ACTIVE-1
y  out  9  recovered row, 0..V_ACTIVE-1
active  out  1  locked and inside the visible region
frame_start  out  1  one-clk pulse on a vsync falling edge while locked
locked  out  1  timing lock status
err  out  1  one-clk pulse on any timing mismatch
err_cnt  out  8  count of err pulses, saturating at 255

Behaviour:
- Reset (rst=0, asynchronous): every output is 0; hc=0, vc=0, good=0; FSM is SEARCH. Previous-sample registers hs_q and vs_q reset to 1.
- Sampling: hsync and vsync each pass through a 2-flop synchroniser in clk. Edges are evaluated only when pix_en=1. A falling edge is hs_q=1 and current=0; hs_q and vs_q update on pix_en cycles.
- hc (11 bit): on an hsync fall, hc becomes 0; otherwise it increments, saturating at 2047.
- vc (10 bit): on a vsync fall, vc becomes 0. Otherwise, on an hsync fall, vc increments. A vsync fall takes priority when both edges occur in the same sample.
- FSM states: SEARCH, CHECK, LOCKED.
  - SEARCH: on a vsync fall, go to CHECK with good=0 and skip=1.
  - CHECK and LOCKED, line check: on each hsync fall, test hc==H_TOTAL-1. The first hsync fall after entering CHECK is exempt; it clears skip.
  - CHECK and LOCKED, frame check: on each vsync fall, test vc==V_TOTAL-1, then update vc.
  - Good frame in CHECK: good increments. When good reaches LOCK_FRAMES, go to LOCKED.
  - Any mismatch, or hc reaching 2047 (sync lost): err pulses, err_cnt increments (saturating), good=0. If the mismatch occurred on a vsync fall, go to CHECK with skip=1; otherwise go to SEARCH.
- Outputs are registered, with one clk of latency after the pix_en sample that caused them.
  - locked=1 exactly while in LOCKED.
  - active=1 when locked, hc is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vc is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - When active: x = hc-(H_SYNC+H_BP) and y = vc-(V_SYNC+V_BP). When not active, x=0 and y=0.
  - frame_start fires on a vsync fall only if the FSM is LOCKED before and after that edge.
- Arithmetic: subtractions are performed at counter width, then truncated to the output width; the range check guarantees no underflow.
- Boundaries:
  - pix_en low: all state holds and pulses deassert.
  - Sync held low indefinitely: no edges occur, hc saturates, err fires once, and the FSM is in SEARCH.
  - Reset mid-frame: the block reacquires lock only after LOCK_FRAMES+1 vsync falls.

Decomposition:
- Shared package vga_timing_pkg holds the 640x480 constants (H_/V_ values above) and the FSM state encoding.
- The VGA timing generator and this block both use the package.
- Sub-module sync_edge_detect (2-flop synchroniser plus falling-edge detect qualified by pix_en) is instantiated twice, once for hsync and once for vsync.

Test Plan:
- Nominal timing from the VGA generator model, LOCK_FRAMES=2, after reset: locked rises 1 clk after the 3rd vsync fall; err_cnt=0; frame_start pulses once per frame thereafter.
- While locked, first visible pixel (hc=144, vc=35): x=0, y=0, active=1. At hc=783, vc=514: x=639, y=479. At hc=784: active=0 and x=0.
- One line shortened to 799 pixels while locked: err pulses once, err_cnt=1, locked falls next clk, and lock returns after 3 good vsync falls.
- Frame with 524 lines: err pulses at that vsync fall, FSM goes to CHECK and not SEARCH, and lock regains after 2 further good frames.
- hsync and vsync held low for 3000 pixel strobes: exactly one err, state SEARCH, locked=0, hc=2047 held.
- rst asserted mid-line with pix_en running: all outputs 0 immediately without waiting for clk; after release, behaviour matches the first scenario. With pix_en tied low, no counter changes.
